// File: rtl/inst_ram_loader_pkg.sv
// Shared definitions for the instruction RAM loader: FSM encoding,
// word geometry and the NOP fill value.
package inst_ram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam int          BYTE_W         = 8;
  localparam logic [31:0] NOP            = 32'h0000_0000;

endpackage

// File: rtl/inst_ram_loader_if.sv
// Byte-stream load channel: control pulses plus a valid/ready byte handshake.
interface inst_ram_loader_if;
  import inst_ram_loader_pkg::*;

  logic              load_start;
  logic              load_end;
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;

  modport master (
    output load_start, load_end, byte_valid, byte_data,
    input  byte_ready
  );

  modport slave (
    input  load_start, load_end, byte_valid, byte_data,
    output byte_ready
  );
endinterface

// File: rtl/inst_ram.sv
// Instruction memory: synchronous write, asynchronous read, and a
// synchronous clear that fills every word with NOP.
module inst_ram
  import inst_ram_loader_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem[i] <= DW'(NOP);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read so the CPU fetch path sees a word the cycle after it is written.
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_ram_loader.sv
// Streams big-endian program bytes into the instruction RAM, one word per
// four accepted bytes, while the CPU fetches from the same RAM.
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  inst_ram_loader_if.slave  bus,
  input  logic [AW-1:0]     a,
  output logic [DW-1:0]     inst,
  output logic              loading,
  output logic              load_done,
  output logic [AW:0]       word_count,
  output logic              load_err
);

  state_t          state_reg, state_next;
  logic [AW-1:0]   ptr_reg;
  logic [1:0]      idx_reg, idx_next;
  logic [AW:0]     count_reg;
  logic            err_reg;
  logic [DW-9:0]   asm_reg;
  logic            accept;
  logic            word_we;
  logic            last_word;

  assign accept    = bus.byte_valid && (state_reg == LOAD);
  // A restart on the same edge as a fourth byte discards that word.
  assign word_we   = accept && (idx_reg == 2'(BYTES_PER_WORD - 1)) && !bus.load_start;
  assign last_word = &ptr_reg;

  always_comb begin
    idx_next = idx_reg;
    if (accept) begin
      idx_next = idx_reg + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.load_start) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        LOAD: begin
          if ((word_we && last_word) || bus.load_end) begin
            state_next = DONE;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    bus.byte_ready = 1'b0;
    loading        = 1'b0;
    load_done      = 1'b0;
    case (state_reg)
      LOAD: begin
        bus.byte_ready = 1'b1;
        loading        = 1'b1;
      end
      DONE:    load_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
      asm_reg   <= '0;
    end else if (bus.load_start) begin
      ptr_reg   <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (state_reg == LOAD) begin
      if (accept) begin
        asm_reg <= {asm_reg[DW-17:0], bus.byte_data};
      end
      if (word_we) begin
        ptr_reg   <= ptr_reg + AW'(1);
        count_reg <= count_reg + (AW+1)'(1);
      end
      // load_end sees the index after this cycle's byte; a nonzero index is a torn word.
      if (bus.load_end) begin
        idx_reg <= '0;
        if (idx_next != 2'd0) begin
          err_reg <= 1'b1;
        end
      end else begin
        idx_reg <= idx_next;
      end
    end
  end

  assign word_count = count_reg;
  assign load_err   = err_reg;

  inst_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (word_we),
    .waddr (ptr_reg),
    .wdata ({asm_reg, bus.byte_data}),
    .raddr (a),
    .rdata (inst)
  );

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader: one task per scenario, each with
// inline checks against hand-computed values.
module tb_inst_ram_loader;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] a;
  logic [DW-1:0] inst;
  logic          loading;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          load_err;

  int checks = 0;
  int errors = 0;

  inst_ram_loader_if bus ();

  inst_ram_loader #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .a          (a),
    .inst       (inst),
    .loading    (loading),
    .load_done  (load_done),
    .word_count (word_count),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic pulse_end();
    bus.load_end = 1'b1;
    tick();
    bus.load_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'hFF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    a = '0;
    #1;
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading got %b want 0", loading); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", load_err); end
    checks++; if (word_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d want 0", word_count); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.byte_ready); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 00000000", inst); end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    logic [7:0] b [8];
    b = '{8'h00, 8'h10, 8'h14, 8'h64, 8'h40, 8'h00, 8'h04, 8'h22};
    pulse_start();
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL basic_loading got %b want 1", loading); end
    checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", bus.byte_ready); end
    for (int i = 0; i < 8; i++) send_byte(b[i]);
    pulse_end();
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", load_err); end
    checks++; if (word_count !== 7'd2) begin errors++; $display("FAIL basic_count got %0d want 2", word_count); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done got %b want 0", bus.byte_ready); end
    a = 6'd0; #1;
    checks++; if (inst !== 32'h00101464) begin errors++; $display("FAIL basic_mem0 got %h want 00101464", inst); end
    a = 6'd1; #1;
    checks++; if (inst !== 32'h40000422) begin errors++; $display("FAIL basic_mem1 got %h want 40000422", inst); end
    a = 6'd2; #1;
    checks++; if (inst !== 32'h00000000) begin errors++; $display("FAIL basic_mem2 got %h want 00000000", inst); end
    $display("test_basic: count=%0d", word_count);
  endtask

  task automatic test_back_pressure();
    logic [7:0] bp [4];
    int k;
    int v;
    bp = '{8'h3C, 8'h00, 8'h0C, 8'h27};
    k = 0;
    pulse_start();
    for (int cyc = 0; cyc < 200 && k < 4; cyc++) begin
      v = int'($urandom_range(0, 1));
      bus.byte_valid = (v != 0);
      bus.byte_data  = (v != 0) ? bp[k] : 8'hFF;
      tick();
      if (v != 0) k++;
    end
    bus.byte_valid = 1'b0;
    tick();
    tick();
    checks++; if (k !== 4) begin errors++; $display("FAIL bp_bound got %0d bytes want 4", k); end
    checks++; if (word_count !== 7'd1) begin errors++; $display("FAIL bp_count got %0d want 1", word_count); end
    a = 6'd0; #1;
    checks++; if (inst !== 32'h3C000C27) begin errors++; $display("FAIL bp_mem0 got %h want 3c000c27", inst); end
    a = 6'd1; #1;
    checks++; if (inst !== 32'h40000422) begin errors++; $display("FAIL bp_mem1 got %h want 40000422", inst); end
    pulse_end();
    checks++; if (load_err !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL bp_end got err=%b done=%b want err=0 done=1", load_err, load_done); end
    $display("test_back_pressure: count=%0d", word_count);
  endtask

  task automatic test_full();
    logic [31:0] exp;
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        checks++; if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL full_ready_last got %b want 1", bus.byte_ready); end
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'(i);
      tick();
    end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1", load_done); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bus.byte_ready); end
    checks++; if (word_count !== 7'd64) begin errors++; $display("FAIL full_count got %0d want 64", word_count); end
    bus.byte_data = 8'hAA;
    for (int i = 0; i < 4; i++) tick();
    bus.byte_valid = 1'b0;
    checks++; if (word_count !== 7'd64) begin errors++; $display("FAIL full_count_extra got %0d want 64", word_count); end
    for (int w = 0; w < 64; w++) begin
      exp = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
      a = AW'(w); #1;
      checks++; if (inst !== exp) begin errors++; $display("FAIL full_mem%0d got %h want %h", w, inst, exp); end
    end
    $display("test_full: count=%0d", word_count);
  endtask

  task automatic test_partial();
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    pulse_end();
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL partial_err got %b want 1", load_err); end
    checks++; if (word_count !== 7'd0) begin errors++; $display("FAIL partial_count got %0d want 0", word_count); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL partial_done got %b want 1", load_done); end
    a = 6'd0; #1;
    checks++; if (inst !== 32'h00010203) begin errors++; $display("FAIL partial_mem0 got %h want 00010203", inst); end
    pulse_start();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL partial_err_clear got %b want 0", load_err); end
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL partial_restart got %b want 1", loading); end
    $display("test_partial: err cleared=%b", ~load_err);
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i));
    rst = 1'b1;
    bus.load_start = 1'b1;
    bus.byte_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    checks++; if (loading !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0 || bus.byte_ready !== 1'b0) begin errors++; $display("FAIL rstmid_flags got ld=%b dn=%b er=%b rdy=%b want 0", loading, load_done, load_err, bus.byte_ready); end
    checks++; if (word_count !== 7'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", word_count); end
    for (int w = 0; w < 64; w++) begin
      a = AW'(w); #1;
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rstmid_mem%0d got %h want 00000000", w, inst); end
    end
    tick();
    pulse_start();
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    a = 6'd0; #1;
    checks++; if (inst !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_mem0 got %h want deadbeef", inst); end
    checks++; if (word_count !== 7'd1) begin errors++; $display("FAIL rstmid_count2 got %0d want 1", word_count); end
    $display("test_reset_mid_load: inst=%h", inst);
  endtask

  task automatic test_simultaneous();
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    bus.load_end = 1'b1;
    send_byte(8'h78);
    bus.load_end = 1'b0;
    checks++; if (word_count !== 7'd1) begin errors++; $display("FAIL sim_count got %0d want 1", word_count); end
    checks++; if (load_err !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL sim_end got err=%b done=%b want err=0 done=1", load_err, load_done); end
    a = 6'd0; #1;
    checks++; if (inst !== 32'h12345678) begin errors++; $display("FAIL sim_mem0 got %h want 12345678", inst); end
    bus.load_start = 1'b1;
    bus.load_end   = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_end   = 1'b0;
    checks++; if (loading !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL sim_start_wins got ld=%b dn=%b want ld=1 dn=0", loading, load_done); end
    // Restart mid-word: the two stale bytes must not leak into the next word.
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_start();
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hF0);
    send_byte(8'h0D);
    pulse_end();
    a = 6'd0; #1;
    checks++; if (inst !== 32'hCAFEF00D) begin errors++; $display("FAIL sim_restart_mem0 got %h want cafef00d", inst); end
    checks++; if (word_count !== 7'd1 || load_err !== 1'b0) begin errors++; $display("FAIL sim_restart got cnt=%0d err=%b want cnt=1 err=0", word_count, load_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_end();
    checks++; if (loading !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL sim_end_idle got ld=%b dn=%b want 0", loading, load_done); end
    $display("test_simultaneous: done");
  endtask

  initial begin
    rst            = 1'b1;
    a              = '0;
    bus.load_start = 1'b0;
    bus.load_end   = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_basic();
    test_back_pressure();
    test_full();
    test_partial();
    test_reset_mid_load();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
